// File: rtl/i2c_regbank_if.sv
// ---------------------------------------------------------------------------
// i2c_regbank_if
// Purpose : APB bus bundle between an APB master and the i2c_regbank
//           register slave. Clock and reset are plain module ports and
//           are not carried here.
// Signals : psel, penable, pwrite  - APB control (master -> slave)
//           paddr[11:0]            - byte address (master -> slave)
//           pwdata[31:0]           - write data (master -> slave)
//           pready, pslverr        - transfer response (slave -> master)
//           prdata[31:0]           - read data (slave -> master)
// ---------------------------------------------------------------------------
interface i2c_regbank_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/i2c_regbank.sv
// ---------------------------------------------------------------------------
// i2c_regbank
// Purpose : APB register bank for NCH I2C controller channels. Each channel
//           owns a 512-byte window (paddr[11:9] = channel, paddr[8:0] =
//           register offset) holding interrupt, control, address, FIFO
//           access and bus-timing registers.
// Build option : define I2C_REGBANK_IRQ_COAL_EN to add a per-channel
//           interrupt coalescing register (COAL) at offset 0x148.
// Ports   :
//   clk, rst           clock, synchronous active-high reset
//   apb                APB slave bundle (i2c_regbank_if.slave)
//   irq                registered OR of all channel interrupts
//   irq_req            per-channel ISR set pulses (8 per channel)
//   sr                 per-channel core status byte (read-only register)
//   cr_set / cr_clr    per-channel hardware set/clear of CR bits
//   cr                 per-channel control register
//   slv_adr            per-channel {TEN_ADR[2:0], ADR[7:1]}
//   rx_pirq            per-channel RX FIFO interrupt level
//   srst               per-channel soft-reset pulse
//   tx_wr / tx_wdat    TX FIFO push strobe and shared write data
//   rx_rd / rx_rdat    RX FIFO pop strobe and per-channel read data
//   tx_ocy / rx_ocy    per-channel FIFO occupancy
//   tsusta..thddat     per-channel bus timing values
// Writes complete with zero wait states; reads take one wait state
// (IDLE -> RWAIT -> RDONE) so prdata can be registered.
// ---------------------------------------------------------------------------
module i2c_regbank #(
    parameter int NCH      = 2,
    parameter int FAW      = 4,
    parameter int TW       = 16,
    parameter int SRST_LEN = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    i2c_regbank_if.slave           apb,
    output logic                   irq,
    input  logic [8*NCH-1:0]       irq_req,
    input  logic [8*NCH-1:0]       sr,
    input  logic [7*NCH-1:0]       cr_set,
    input  logic [7*NCH-1:0]       cr_clr,
    output logic [7*NCH-1:0]       cr,
    output logic [10*NCH-1:0]      slv_adr,
    output logic [5*NCH-1:0]       rx_pirq,
    output logic [NCH-1:0]         srst,
    output logic [NCH-1:0]         tx_wr,
    output logic [9:0]             tx_wdat,
    output logic [NCH-1:0]         rx_rd,
    input  logic [8*NCH-1:0]       rx_rdat,
    input  logic [(FAW+1)*NCH-1:0] tx_ocy,
    input  logic [(FAW+1)*NCH-1:0] rx_ocy,
    output logic [TW*NCH-1:0]      tsusta,
    output logic [TW*NCH-1:0]      tsusto,
    output logic [TW*NCH-1:0]      thdsta,
    output logic [TW*NCH-1:0]      tsudat,
    output logic [TW*NCH-1:0]      tbuf,
    output logic [TW*NCH-1:0]      thigh,
    output logic [TW*NCH-1:0]      tlow,
    output logic [TW*NCH-1:0]      thddat
);

    localparam logic [3:0] NCH_W = 4'(NCH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RWAIT = 2'd1,
        S_RDONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // -----------------------------------------------------------------------
    // Address decode (shared by all channels)
    // -----------------------------------------------------------------------
    logic [2:0]  ch;
    logic [8:0]  off;
    logic        ch_ok;
    logic        off_mapped;
    logic        off_ro;
    logic        off_tim;
    logic [2:0]  tim_idx;
    logic        addr_err;
    logic        wr_err;
    logic        wr_acc;
    logic        wr_ok;
    logic        rd_start;

    assign ch      = apb.paddr[11:9];
    assign off     = apb.paddr[8:0];
    assign ch_ok   = ({1'b0, ch} < NCH_W);
    // Timing registers occupy 0x128..0x144, one word each, in port order.
    assign off_tim = (off >= 9'h128) && (off <= 9'h144) && (off[1:0] == 2'b00);
    assign tim_idx = 3'((off - 9'h128) >> 2);

    always_comb begin
        off_mapped = 1'b1;
        off_ro     = 1'b0;
        case (off)
            9'h01C, 9'h020, 9'h028, 9'h040,
            9'h100, 9'h108, 9'h110, 9'h11C, 9'h120: off_ro = 1'b0;
            9'h104, 9'h10C, 9'h114, 9'h118:         off_ro = 1'b1;
`ifdef I2C_REGBANK_IRQ_COAL_EN
            9'h148:                                 off_ro = 1'b0;
`endif
            default:                                off_mapped = off_tim;
        endcase
    end

    assign addr_err = ~ch_ok | ~off_mapped;
    assign wr_err   = addr_err | off_ro;
    // Writes finish in their first access cycle, only ever seen in IDLE.
    assign wr_acc   = apb.psel & apb.penable & apb.pwrite & (state_q == S_IDLE);
    assign wr_ok    = wr_acc & ~wr_err;
    assign rd_start = apb.psel & ~apb.penable & ~apb.pwrite & (state_q == S_IDLE);

    // -----------------------------------------------------------------------
    // Read FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rd_start) state_d = S_RWAIT;
            S_RWAIT: state_d = S_RDONE;
            S_RDONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Read data path: captured at the end of RWAIT, presented in RDONE
    // -----------------------------------------------------------------------
    logic [NCH*32-1:0] rd_val;
    logic [31:0]       rd_mux;
    logic [31:0]       prdata_q;
    logic              rd_err_q;
    logic              rd_rx_q;
    logic [2:0]        rd_ch_q;

    always_comb begin
        rd_mux = 32'h0;
        for (int c = 0; c < NCH; c++) begin
            if ({1'b0, ch} == 4'(c)) rd_mux = rd_val[c*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prdata_q <= 32'h0;
            rd_err_q <= 1'b0;
            rd_rx_q  <= 1'b0;
            rd_ch_q  <= 3'd0;
        end else if (state_q == S_RWAIT) begin
            prdata_q <= addr_err ? 32'hDEADBEEF : rd_mux;
            rd_err_q <= addr_err;
            rd_rx_q  <= (off == 9'h10C) & ~addr_err;
            rd_ch_q  <= ch;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = (state_q != S_RWAIT);
    assign apb.pslverr = (wr_acc & wr_err) | ((state_q == S_RDONE) & rd_err_q);
    assign tx_wdat     = apb.pwdata[9:0];

    // -----------------------------------------------------------------------
    // Interrupt output
    // -----------------------------------------------------------------------
    logic [NCH-1:0] ch_int;
    logic           irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |ch_int;
        end
    end

    assign irq = irq_q;

    // -----------------------------------------------------------------------
    // Per-channel register sets
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic          sel_wr;
        logic          blocked;
        logic          gie_q;
        logic [7:0]    isr_q, isr_d;
        logic [7:0]    ier_q;
        logic [6:0]    cr_q, cr_d;
        logic [6:0]    adr_q;
        logic [2:0]    ten_q;
        logic [4:0]    pirq_q;
        logic [3:0]    srst_cnt_q;
        logic [TW-1:0] tim_q [8];
        logic [7:0]    w1c;
        logic [7:0]    pend;
        logic [31:0]   rv;
`ifdef I2C_REGBANK_IRQ_COAL_EN
        logic [31:0]   coal_q;
        logic [15:0]   tmo_q;
        logic [3:0]    npend;
        logic          thr_hit;
        logic          tmo_hit;
`endif

        assign sel_wr  = wr_ok & ({1'b0, ch} == 4'(gi));
        assign blocked = (srst_cnt_q != 4'd0);
        assign w1c     = (sel_wr && off == 9'h020) ? apb.pwdata[7:0] : 8'h00;
        assign pend    = isr_q & ier_q;

        // ISR and CR freeze entirely while the channel is in soft reset.
        always_comb begin
            isr_d = (isr_q & ~w1c) | irq_req[gi*8 +: 8];
            cr_d  = (cr_q | cr_set[gi*7 +: 7]) & ~cr_clr[gi*7 +: 7];
            if (sel_wr && off == 9'h100) cr_d = apb.pwdata[6:0];
            if (blocked) begin
                isr_d = isr_q;
                cr_d  = cr_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                gie_q      <= 1'b0;
                isr_q      <= 8'h00;
                ier_q      <= 8'h00;
                cr_q       <= 7'h00;
                adr_q      <= 7'h00;
                ten_q      <= 3'h0;
                pirq_q     <= 5'd1;
                srst_cnt_q <= 4'd0;
                for (int t = 0; t < 8; t++) tim_q[t] <= TW'(50);
`ifdef I2C_REGBANK_IRQ_COAL_EN
                coal_q     <= 32'h0;
`endif
            end else begin
                isr_q <= isr_d;
                cr_q  <= cr_d;
                if (srst_cnt_q != 4'd0) srst_cnt_q <= srst_cnt_q - 4'd1;
                if (sel_wr) begin
                    case (off)
                        9'h01C: gie_q  <= apb.pwdata[31];
                        9'h028: ier_q  <= apb.pwdata[7:0];
                        // A reload here also restarts a pulse already running.
                        9'h040: if (apb.pwdata == 32'hA) srst_cnt_q <= 4'(SRST_LEN);
                        9'h110: adr_q  <= apb.pwdata[7:1];
                        9'h11C: ten_q  <= apb.pwdata[2:0];
                        9'h120: pirq_q <= apb.pwdata[4:0];
`ifdef I2C_REGBANK_IRQ_COAL_EN
                        9'h148: coal_q <= apb.pwdata;
`endif
                        default: if (off_tim) tim_q[tim_idx] <= apb.pwdata[TW-1:0];
                    endcase
                end
            end
        end

        always_comb begin
            rv = 32'h0;
            case (off)
                9'h01C: rv = {gie_q, 31'h0};
                9'h020: rv = {24'h0, isr_q};
                9'h028: rv = {24'h0, ier_q};
                9'h100: rv = {25'h0, cr_q};
                9'h104: rv = {24'h0, sr[gi*8 +: 8]};
                9'h10C: rv = {24'h0, rx_rdat[gi*8 +: 8]};
                9'h110: rv = {24'h0, adr_q, 1'b0};
                9'h114: rv = 32'(tx_ocy[gi*(FAW+1) +: (FAW+1)]);
                9'h118: rv = 32'(rx_ocy[gi*(FAW+1) +: (FAW+1)]);
                9'h11C: rv = {29'h0, ten_q};
                9'h120: rv = {27'h0, pirq_q};
`ifdef I2C_REGBANK_IRQ_COAL_EN
                9'h148: rv = coal_q;
`endif
                default: if (off_tim) rv = 32'(tim_q[tim_idx]);
            endcase
        end

        assign rd_val[gi*32 +: 32] = rv;

`ifdef I2C_REGBANK_IRQ_COAL_EN
        // Timeout counter runs while an enabled ISR bit is pending, saturates
        // at the programmed timeout and restarts whenever software clears ISR.
        always_ff @(posedge clk) begin
            if (rst) begin
                tmo_q <= 16'h0;
            end else if ((|w1c) || !(|pend)) begin
                tmo_q <= 16'h0;
            end else if (tmo_q != coal_q[31:16]) begin
                tmo_q <= tmo_q + 16'h1;
            end
        end

        always_comb begin
            npend = 4'd0;
            for (int b = 0; b < 8; b++) npend = npend + 4'(pend[b]);
        end

        assign thr_hit = ({12'h0, npend} >= coal_q[15:0]);
        assign tmo_hit = (coal_q[31:16] != 16'h0) && (|pend) && (tmo_q == coal_q[31:16]);
        assign ch_int[gi] = gie_q & ((coal_q[15:0] == 16'h0) ? (|pend) : (thr_hit | tmo_hit));
`else
        assign ch_int[gi] = gie_q & (|pend);
`endif

        assign cr[gi*7 +: 7]       = cr_q;
        assign slv_adr[gi*10 +: 10] = {ten_q, adr_q};
        assign rx_pirq[gi*5 +: 5]  = pirq_q;
        assign srst[gi]            = blocked;
        assign tx_wr[gi]           = sel_wr & (off == 9'h108) & ~blocked;
        assign rx_rd[gi]           = (state_q == S_RDONE) & rd_rx_q &
                                     (rd_ch_q == 3'(gi)) & ~blocked;

        assign tsusta[gi*TW +: TW] = tim_q[0];
        assign tsusto[gi*TW +: TW] = tim_q[1];
        assign thdsta[gi*TW +: TW] = tim_q[2];
        assign tsudat[gi*TW +: TW] = tim_q[3];
        assign tbuf[gi*TW +: TW]   = tim_q[4];
        assign thigh[gi*TW +: TW]  = tim_q[5];
        assign tlow[gi*TW +: TW]   = tim_q[6];
        assign thddat[gi*TW +: TW] = tim_q[7];
    end

endmodule

// File: tb/tb_i2c_regbank.sv
// ---------------------------------------------------------------------------
// tb_i2c_regbank
// Purpose : self-checking bench for i2c_regbank (NCH=2, FAW=4, TW=16,
//           SRST_LEN=10). A table of APB read/write vectors with expected
//           data/error is replayed, followed by hand-written sequences for
//           interrupt, soft-reset, back-to-back RX and reset-abort cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_regbank;
    localparam int NCH = 2;
    localparam int FAW = 4;
    localparam int TW  = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   irq;
    logic [8*NCH-1:0]       irq_req;
    logic [8*NCH-1:0]       sr;
    logic [7*NCH-1:0]       cr_set, cr_clr;
    logic [7*NCH-1:0]       cr;
    logic [10*NCH-1:0]      slv_adr;
    logic [5*NCH-1:0]       rx_pirq;
    logic [NCH-1:0]         srst;
    logic [NCH-1:0]         tx_wr;
    logic [9:0]             tx_wdat;
    logic [NCH-1:0]         rx_rd;
    logic [8*NCH-1:0]       rx_rdat;
    logic [(FAW+1)*NCH-1:0] tx_ocy, rx_ocy;
    logic [TW*NCH-1:0]      tsusta, tsusto, thdsta, tsudat, tbuf, thigh, tlow, thddat;

    i2c_regbank_if bus();

    i2c_regbank #(.NCH(NCH), .FAW(FAW), .TW(TW), .SRST_LEN(10)) dut (
        .clk(clk), .rst(rst), .apb(bus), .irq(irq), .irq_req(irq_req),
        .sr(sr), .cr_set(cr_set), .cr_clr(cr_clr), .cr(cr),
        .slv_adr(slv_adr), .rx_pirq(rx_pirq), .srst(srst),
        .tx_wr(tx_wr), .tx_wdat(tx_wdat), .rx_rd(rx_rd), .rx_rdat(rx_rdat),
        .tx_ocy(tx_ocy), .rx_ocy(rx_ocy),
        .tsusta(tsusta), .tsusto(tsusto), .thdsta(thdsta), .tsudat(tsudat),
        .tbuf(tbuf), .thigh(thigh), .tlow(tlow), .thddat(thddat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Strobe monitors: monotonic counters, sampled mid-cycle.
    int tx0_cnt = 0, tx1_cnt = 0, rx0_cnt = 0, rx1_cnt = 0;
    int srst0_cnt = 0, srst1_cnt = 0;
    logic [9:0] last_tx1_wdat = 10'h0;

    always @(negedge clk) begin
        tx0_cnt   += int'(tx_wr[0]);
        tx1_cnt   += int'(tx_wr[1]);
        rx0_cnt   += int'(rx_rd[0]);
        rx1_cnt   += int'(rx_rd[1]);
        srst0_cnt += int'(srst[0]);
        srst1_cnt += int'(srst[1]);
        if (tx_wr[1]) last_tx1_wdat = tx_wdat;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Both APB tasks start at posedge+1 and return at posedge+1 after the
    // completing edge, so consecutive calls are back-to-back transfers.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] wd,
                             output logic err, output int waits);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = a; bus.pwdata = wd;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.pready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        err = bus.pslverr;
        $display("WR addr=0x%03h data=0x%08h slverr=%0d waits=%0d", a, wd, err, waits);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                            output logic err, output int waits,
                            output logic first_rdy, output logic [1:0] rxd);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = a;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        waits = 0;
        @(negedge clk);
        first_rdy = bus.pready;
        while (!bus.pready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        d   = bus.prdata;
        err = bus.pslverr;
        rxd = rx_rd;
        $display("RD addr=0x%03h data=0x%08h slverr=%0d waits=%0d", a, d, err, waits);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [22];

    initial begin
        logic [31:0] d;
        logic        e, fr;
        logic [1:0]  rxd;
        int          w;
        int          s0, s1, t0, t1, r0, r1;

        vecs[0]  = '{1'b0, 12'h328, 32'h0,        32'h00000032, 1'b0};
        vecs[1]  = '{1'b0, 12'h120, 32'h0,        32'h00000001, 1'b0};
        vecs[2]  = '{1'b1, 12'h128, 32'hABCD1234, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 12'h128, 32'h0,        32'h00001234, 1'b0};
        vecs[4]  = '{1'b1, 12'h110, 32'h000000FF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 12'h110, 32'h0,        32'h000000FE, 1'b0};
        vecs[6]  = '{1'b1, 12'h31C, 32'h0000000F, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 12'h31C, 32'h0,        32'h00000007, 1'b0};
        vecs[8]  = '{1'b1, 12'h104, 32'h00000001, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 12'h104, 32'h0,        32'h0000005A, 1'b0};
        vecs[10] = '{1'b1, 12'h100, 32'h00000055, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 12'h100, 32'h0,        32'h00000055, 1'b0};
        vecs[12] = '{1'b1, 12'h344, 32'h00010077, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 12'h344, 32'h0,        32'h00000077, 1'b0};
        vecs[14] = '{1'b0, 12'h114, 32'h0,        32'h00000009, 1'b0};
        vecs[15] = '{1'b0, 12'h318, 32'h0,        32'h00000010, 1'b0};
        vecs[16] = '{1'b0, 12'h500, 32'h0,        32'hDEADBEEF, 1'b1};
        vecs[17] = '{1'b0, 12'h148, 32'h0,        32'hDEADBEEF, 1'b1};
        vecs[18] = '{1'b1, 12'h00C, 32'h12345678, 32'h0,        1'b1};
        vecs[19] = '{1'b1, 12'h510, 32'h00000012, 32'h0,        1'b1};
        vecs[20] = '{1'b0, 12'h21C, 32'h0,        32'h00000000, 1'b0};
        vecs[21] = '{1'b1, 12'h10C, 32'h00000001, 32'h0,        1'b1};

        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 12'h0; bus.pwdata = 32'h0;
        irq_req = '0; cr_set = '0; cr_clr = '0;
        sr      = {8'h00, 8'h5A};
        rx_rdat = '0;
        tx_ocy  = {5'd0, 5'd9};
        rx_ocy  = {5'd16, 5'd3};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("rst_irq",     32'(irq), 32'h0);
        check("rst_srst",    32'(srst), 32'h0);
        check("rst_cr",      32'(cr), 32'h0);
        check("rst_slv_adr", 32'(slv_adr), 32'h0);
        check("rst_rx_pirq", 32'(rx_pirq), 32'h00000021);
        check("rst_tsusta",  tsusta, 32'h00320032);
        check("rst_thddat",  thddat, 32'h00320032);
        check("rst_pready",  32'(bus.pready), 32'h1);
        check("rst_pslverr", 32'(bus.pslverr), 32'h0);
        check("rst_prdata",  bus.prdata, 32'h0);
        @(posedge clk); #1;

        // ---- first read after reset: one wait state ----
        apb_read(12'h328, d, e, w, fr, rxd);
        check("rd1_first_pready", 32'(fr), 32'h0);
        check("rd1_waits",        32'(w), 32'h1);
        check("rd1_data",         d, 32'h00000032);
        check("rd1_err",          32'(e), 32'h0);

        // ---- table ----
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e, w);
                check($sformatf("vec%0d_waits", i), 32'(w), 32'h0);
            end else begin
                apb_read(vecs[i].addr, d, e, w, fr, rxd);
                check($sformatf("vec%0d_waits", i), 32'(w), 32'h1);
                check($sformatf("vec%0d_data", i), d, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
        end

        @(negedge clk);
        check("slv_adr_ch0", 32'(slv_adr[9:0]),   32'h07F);
        check("slv_adr_ch1", 32'(slv_adr[19:10]), 32'h380);
        check("tsusta_ch0",  32'(tsusta[15:0]),   32'h1234);
        check("thddat_ch1",  32'(thddat[31:16]),  32'h0077);
        check("cr_ch0",      32'(cr[6:0]),        32'h55);

        // ---- CR hardware set/clear: clear wins over set ----
        @(posedge clk); #1;
        cr_set[6:0] = 7'h03; cr_clr[6:0] = 7'h01;
        @(posedge clk); #1;
        cr_set = '0; cr_clr = '0;
        @(negedge clk);
        check("cr_hw_setclr", 32'(cr[6:0]), 32'h56);

        // ---- interrupt path ----
        @(posedge clk); #1;
        apb_write(12'h028, 32'h00000001, e, w);
        apb_write(12'h01C, 32'h80000000, e, w);
        @(negedge clk);
        check("irq_idle", 32'(irq), 32'h0);
        @(posedge clk); #1;
        irq_req[0] = 1'b1;
        @(posedge clk); #1;
        irq_req[0] = 1'b0;
        @(negedge clk);
        check("irq_latency", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        @(posedge clk); #1;
        apb_write(12'h020, 32'h00000001, e, w);
        @(posedge clk);
        @(negedge clk);
        check("irq_w1c", 32'(irq), 32'h0);

        // ---- same-cycle irq_req and W1C of bit 3 ----
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0;
        bus.paddr = 12'h020; bus.pwdata = 32'h00000008;
        @(posedge clk); #1;
        bus.penable = 1'b1; irq_req[3] = 1'b1;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; irq_req[3] = 1'b0;
        $display("WR addr=0x020 data=0x00000008 with irq_req[3]");
        apb_read(12'h020, d, e, w, fr, rxd);
        check("isr_set_wins", d, 32'h00000008);
        check("irq_masked", 32'(irq), 32'h0);
        apb_write(12'h020, 32'h00000008, e, w);
        apb_read(12'h020, d, e, w, fr, rxd);
        check("isr_w1c_bit3", d, 32'h00000000);

        // ---- soft reset on ch1 blocks TX writes ----
        s1 = srst1_cnt; t1 = tx1_cnt; t0 = tx0_cnt;
        apb_write(12'h240, 32'h0000000A, e, w);
        apb_write(12'h308, 32'h00000155, e, w);
        check("tx_blocked_err", 32'(e), 32'h0);
        repeat (14) @(posedge clk);
        #1;
        check("srst1_len", 32'(srst1_cnt - s1), 32'd10);
        check("tx1_blocked", 32'(tx1_cnt - t1), 32'd0);
        apb_write(12'h308, 32'h000002AA, e, w);
        @(negedge clk);
        check("tx1_after", 32'(tx1_cnt - t1), 32'd1);
        check("tx1_wdat", 32'(last_tx1_wdat), 32'h2AA);
        check("tx0_idle", 32'(tx0_cnt - t0), 32'd0);
        @(posedge clk); #1;

        // ---- SOFTR rewrite restarts the pulse; other values ignored ----
        s0 = srst0_cnt;
        apb_write(12'h040, 32'h0000000A, e, w);
        apb_write(12'h040, 32'h0000000A, e, w);
        repeat (16) @(posedge clk);
        #1;
        check("srst0_restart", 32'(srst0_cnt - s0), 32'd12);
        s0 = srst0_cnt;
        apb_write(12'h040, 32'h0000000B, e, w);
        repeat (12) @(posedge clk);
        #1;
        check("srst0_badkey", 32'(srst0_cnt - s0), 32'd0);

        // ---- RX read on a nonexistent channel ----
        r0 = rx0_cnt; r1 = rx1_cnt;
        apb_read(12'h50C, d, e, w, fr, rxd);
        check("badch_err",  32'(e), 32'h1);
        check("badch_data", d, 32'hDEADBEEF);
        @(negedge clk);
        check("badch_no_rxrd", 32'((rx0_cnt - r0) + (rx1_cnt - r1)), 32'd0);
        @(posedge clk); #1;

        // ---- back-to-back RX reads on ch0 ----
        r0 = rx0_cnt; r1 = rx1_cnt;
        rx_rdat[7:0] = 8'hA5;
        apb_read(12'h10C, d, e, w, fr, rxd);
        check("rx1_data", d, 32'h000000A5);
        check("rx1_strobe", 32'(rxd), 32'h1);
        rx_rdat[7:0] = 8'h3C;
        apb_read(12'h10C, d, e, w, fr, rxd);
        check("rx2_data", d, 32'h0000003C);
        check("rx2_strobe", 32'(rxd), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("rx0_count", 32'(rx0_cnt - r0), 32'd2);
        check("rx1_count", 32'(rx1_cnt - r1), 32'd0);

        // ---- reset during RWAIT aborts the RX read ----
        r0 = rx0_cnt;
        bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = 12'h10C;
        @(posedge clk); #1;
        bus.penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("abort_rwait_pready", 32'(bus.pready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        $display("RD addr=0x10C aborted by rst");
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_no_rxrd", 32'(rx0_cnt - r0), 32'd0);
        check("abort_pready",  32'(bus.pready), 32'h1);
        check("abort_prdata",  bus.prdata, 32'h0);
        check("abort_cr",      32'(cr), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
